// File: rtl/sm_mem_arb_pkg.sv
// sm_mem_arb_pkg: shared definitions for the two-port data-memory arbiter.
//   PORT_CPU / PORT_DBG : requester indices used for grant vectors and tags.
//   rsp_tag_t           : one-cycle read-response tag (pending flag + owning port).
package sm_mem_arb_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef struct packed {
    logic rd_pending;
    logic rd_port;
  } rsp_tag_t;

  localparam rsp_tag_t RSP_TAG_IDLE = '{rd_pending: 1'b0, rd_port: PORT_CPU};

endpackage

// File: rtl/sm_arb_rr2.sv
// sm_arb_rr2: two-requester combinational grant logic with a last-winner register.
// Optional feature macro: SM_MEM_ARB_RR_EN
//   defined   -> round-robin on contention (winner is the port that did not win last)
//   undefined -> fixed priority, CPU wins contention; last winner still tracked
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset (last winner -> debug port)
//   en_i           grant enable; no grant is issued while low
//   req_i[1:0]     requests, indexed by PORT_CPU / PORT_DBG
//   gnt_o[1:0]     one-hot (or zero) grant, combinational from req_i and state
module sm_arb_rr2
  import sm_mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_winner_q, last_winner_d;
  logic contention_winner;
  logic winner;

`ifdef SM_MEM_ARB_RR_EN
  assign contention_winner = ~last_winner_q;
`else
  assign contention_winner = PORT_CPU;
`endif

  always_comb begin
    winner        = last_winner_q;
    gnt_o         = 2'b00;
    last_winner_d = last_winner_q;
    case (req_i)
      2'b01:   winner = PORT_CPU;
      2'b10:   winner = PORT_DBG;
      2'b11:   winner = contention_winner;
      default: winner = last_winner_q;
    endcase
    if (en_i && (req_i != 2'b00)) begin
      gnt_o[winner] = 1'b1;
      last_winner_d = winner;
    end
  end

  // Reset to the debug port so the CPU wins the first contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_winner_q <= PORT_DBG;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end

endmodule

// File: rtl/sm_mem_arbiter.sv
// sm_mem_arbiter: shares one single-cycle data memory between a CPU port (c_*) and
// a debug/loader port (d_*). One access per cycle, zero-latency grant, read data
// returned one cycle after the read grant to the port that issued it.
// Optional feature macro: SM_MEM_ARB_RR_EN (round-robin contention, see sm_arb_rr2).
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   c_req_i/c_we_i/c_addr_i/c_wdata_i  CPU request (held until c_gnt_o)
//   c_gnt_o/c_rvalid_o/c_rdata_o       CPU grant and read response
//   c_stall_o                          CPU hold (c_req_i & ~c_gnt_o)
//   d_*                                debug port, same rules as c_*
//   m_en_o/m_we_o/m_addr_o/m_wdata_o   memory strobe and write/address/data
//   m_rdata_i                          memory read data, one cycle after a read strobe
module sm_mem_arbiter
  import sm_mem_arb_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          c_req_i,
  input  logic          c_we_i,
  input  logic [AW-1:0] c_addr_i,
  input  logic [DW-1:0] c_wdata_i,
  output logic          c_gnt_o,
  output logic          c_rvalid_o,
  output logic [DW-1:0] c_rdata_o,
  output logic          c_stall_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          m_en_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic [DW-1:0] m_rdata_i
);

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          sel_we;
  rsp_tag_t      tag_q, tag_d;
  logic [DW-1:0] c_rdata_q, d_rdata_q;
  logic          c_rvalid, d_rvalid;

  assign req = {d_req_i, c_req_i};

  sm_arb_rr2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (~rst_i),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign c_gnt_o   = gnt[PORT_CPU];
  assign d_gnt_o   = gnt[PORT_DBG];
  assign c_stall_o = c_req_i & ~gnt[PORT_CPU];

  // Memory-side mux: the debug fields are selected only when it holds the grant.
  always_comb begin
    sel_we    = c_we_i;
    m_addr_o  = c_addr_i;
    m_wdata_o = c_wdata_i;
    if (gnt[PORT_DBG]) begin
      sel_we    = d_we_i;
      m_addr_o  = d_addr_i;
      m_wdata_o = d_wdata_i;
    end
    m_en_o = |gnt;
    m_we_o = (|gnt) & sel_we;
  end

  // Tag lives exactly one cycle: set on a read grant, cleared otherwise.
  always_comb begin
    tag_d            = RSP_TAG_IDLE;
    tag_d.rd_pending = (|gnt) & ~sel_we;
    tag_d.rd_port    = gnt[PORT_DBG] ? PORT_DBG : PORT_CPU;
  end

  // Gating with rst_i drops a response whose grant preceded the reset cycle.
  assign c_rvalid = ~rst_i & tag_q.rd_pending & (tag_q.rd_port == PORT_CPU);
  assign d_rvalid = ~rst_i & tag_q.rd_pending & (tag_q.rd_port == PORT_DBG);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q     <= RSP_TAG_IDLE;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      tag_q <= tag_d;
      if (c_rvalid) c_rdata_q <= m_rdata_i;
      if (d_rvalid) d_rdata_q <= m_rdata_i;
    end
  end

  // Memory data passes straight through in the rvalid cycle, then is held.
  always_comb begin
    c_rvalid_o = c_rvalid;
    d_rvalid_o = d_rvalid;
    c_rdata_o  = c_rvalid ? m_rdata_i : c_rdata_q;
    d_rdata_o  = d_rvalid ? m_rdata_i : d_rdata_q;
    if (rst_i) begin
      c_rdata_o = '0;
      d_rdata_o = '0;
    end
  end

endmodule

// File: tb/tb_sm_mem_arbiter.sv
module tb_sm_mem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          c_req, c_we, c_gnt, c_rvalid, c_stall;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  logic [DW-1:0] mem [256];

  int total = 0;
  int bad   = 0;

  sm_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .c_req_i    (c_req),
    .c_we_i     (c_we),
    .c_addr_i   (c_addr),
    .c_wdata_i  (c_wdata),
    .c_gnt_o    (c_gnt),
    .c_rvalid_o (c_rvalid),
    .c_rdata_o  (c_rdata),
    .c_stall_o  (c_stall),
    .d_req_i    (d_req),
    .d_we_i     (d_we),
    .d_addr_i   (d_addr),
    .d_wdata_i  (d_wdata),
    .d_gnt_o    (d_gnt),
    .d_rvalid_o (d_rvalid),
    .d_rdata_o  (d_rdata),
    .m_en_o     (m_en),
    .m_we_o     (m_we),
    .m_addr_o   (m_addr),
    .m_wdata_o  (m_wdata),
    .m_rdata_i  (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (m_en && !m_we) m_rdata <= mem[m_addr];
    if (m_en && m_we) mem[m_addr] <= m_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    c_req = 1'b1; c_addr = 8'h05;
    d_req = 1'b1; d_addr = 8'h02;
    tick();
    @(negedge clk);
    total++; if (c_gnt !== 1'b0) begin bad++; $display("FAIL rst_c_gnt got=%b want=0", c_gnt); end
    total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL rst_d_gnt got=%b want=0", d_gnt); end
    total++; if (m_en !== 1'b0) begin bad++; $display("FAIL rst_m_en got=%b want=0", m_en); end
    total++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      bad++; $display("FAIL rst_rvalid got=%b%b want=00", c_rvalid, d_rvalid);
    end
    total++; if (c_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      bad++; $display("FAIL rst_rdata got=%h/%h want=0/0", c_rdata, d_rdata);
    end
    tick();
  endtask

  // First cycle out of reset: CPU read of address 5.
  task automatic test_cpu_read();
    rst = 1'b0;
    idle_inputs();
    c_req = 1'b1; c_addr = 8'h05;
    @(negedge clk);
    total++; if (c_gnt !== 1'b1) begin bad++; $display("FAIL rd5_c_gnt got=%b want=1", c_gnt); end
    total++; if (c_stall !== 1'b0) begin bad++; $display("FAIL rd5_stall got=%b want=0", c_stall); end
    total++; if (m_en !== 1'b1 || m_we !== 1'b0 || m_addr !== 8'h05) begin
      bad++; $display("FAIL rd5_mem got=%b%b/%h want=10/05", m_en, m_we, m_addr);
    end
    tick();
    c_req = 1'b0;
    @(negedge clk);
    total++; if (c_rvalid !== 1'b1) begin bad++; $display("FAIL rd5_rvalid got=%b want=1", c_rvalid); end
    total++; if (c_rdata !== 32'h1234ABCD) begin
      bad++; $display("FAIL rd5_rdata got=%h want=1234abcd", c_rdata);
    end
    total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL rd5_d_rvalid got=%b want=0", d_rvalid); end
    tick();
    @(negedge clk);
    total++; if (c_rvalid !== 1'b0) begin bad++; $display("FAIL rd5_rv_end got=%b want=0", c_rvalid); end
    total++; if (c_rdata !== 32'h1234ABCD) begin
      bad++; $display("FAIL rd5_hold got=%h want=1234abcd", c_rdata);
    end
  endtask

  task automatic test_dbg_write_read();
    idle_inputs();
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (d_gnt !== 1'b1 || c_gnt !== 1'b0) begin
      bad++; $display("FAIL wr_gnt got=c%b d%b want=c0 d1", c_gnt, d_gnt);
    end
    total++; if (m_we !== 1'b1 || m_addr !== 8'h10 || m_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wr_mem got=%b/%h/%h want=1/10/deadbeef", m_we, m_addr, m_wdata);
    end
    tick();
    idle_inputs();
    c_req = 1'b1; c_addr = 8'h10;
    @(negedge clk);
    total++; if (c_gnt !== 1'b1) begin bad++; $display("FAIL wrrd_c_gnt got=%b want=1", c_gnt); end
    total++; if (d_rvalid !== 1'b0 || c_rvalid !== 1'b0) begin
      bad++; $display("FAIL wr_no_rvalid got=c%b d%b want=c0 d0", c_rvalid, d_rvalid);
    end
    tick();
    c_req = 1'b0;
    @(negedge clk);
    total++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wrrd_data got=%b/%h want=1/deadbeef", c_rvalid, c_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    logic exp_c, prev_c, have_prev;
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    c_req = 1'b1; c_addr = 8'h01;
    d_req = 1'b1; d_addr = 8'h02;
    prev_c = 1'b0; have_prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
`ifdef SM_MEM_ARB_RR_EN
      exp_c = (i % 2 == 0);
`else
      exp_c = 1'b1;
`endif
      @(negedge clk);
      total++; if (c_gnt !== exp_c || d_gnt !== ~exp_c) begin
        bad++; $display("FAIL cont%0d_gnt got=c%b d%b want=c%b d%b", i, c_gnt, d_gnt, exp_c, ~exp_c);
      end
      total++; if (c_stall !== ~exp_c) begin
        bad++; $display("FAIL cont%0d_stall got=%b want=%b", i, c_stall, ~exp_c);
      end
      total++; if (m_addr !== (exp_c ? 8'h01 : 8'h02)) begin
        bad++; $display("FAIL cont%0d_addr got=%h want=%h", i, m_addr, exp_c ? 8'h01 : 8'h02);
      end
      if (have_prev) begin
        total++; if (c_rvalid !== prev_c || d_rvalid !== ~prev_c) begin
          bad++; $display("FAIL cont%0d_rvalid got=c%b d%b want=c%b d%b", i, c_rvalid, d_rvalid,
                          prev_c, ~prev_c);
        end
      end
      prev_c = exp_c; have_prev = 1'b1;
      tick();
    end
    c_req = 1'b0;
    @(negedge clk);
    total++; if (d_gnt !== 1'b1 || c_stall !== 1'b0) begin
      bad++; $display("FAIL cont_release got=d%b stall%b want=d1 stall0", d_gnt, c_stall);
    end
    total++; if (prev_c ? (c_rdata !== 32'hA0000001) : (d_rdata !== 32'hB0000002)) begin
      bad++; $display("FAIL cont_last_data got=%h/%h want_port_c=%b", c_rdata, d_rdata, prev_c);
    end
    tick();
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_discard();
    idle_inputs();
    c_req = 1'b1; c_addr = 8'h05;
    @(negedge clk);
    total++; if (c_gnt !== 1'b1) begin bad++; $display("FAIL disc_gnt got=%b want=1", c_gnt); end
    tick();
    c_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      bad++; $display("FAIL disc_rvalid got=c%b d%b want=c0 d0", c_rvalid, d_rvalid);
    end
    total++; if (c_rdata !== 32'h0 || d_rdata !== 32'h0 || m_en !== 1'b0) begin
      bad++; $display("FAIL disc_outs got=%h/%h/%b want=0/0/0", c_rdata, d_rdata, m_en);
    end
    tick();
    rst = 1'b0;
    c_req = 1'b1; c_addr = 8'h03;
    d_req = 1'b1; d_addr = 8'h02;
    @(negedge clk);
    total++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      bad++; $display("FAIL disc_first_cont got=c%b d%b want=c1 d0", c_gnt, d_gnt);
    end
    total++; if (c_rvalid !== 1'b0) begin bad++; $display("FAIL disc_late_rv got=%b want=0", c_rvalid); end
    tick();
    idle_inputs();
    @(negedge clk);
    total++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hC0000003) begin
      bad++; $display("FAIL disc_after got=%b/%h want=1/c0000003", c_rvalid, c_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    c_req = 1'b1; c_addr = 8'h01;
    @(negedge clk);
    total++; if (c_gnt !== 1'b1 || m_addr !== 8'h01) begin
      bad++; $display("FAIL b2b0 got=%b/%h want=1/01", c_gnt, m_addr);
    end
    tick();
    idle_inputs();
    d_req = 1'b1; d_addr = 8'h02;
    @(negedge clk);
    total++; if (d_gnt !== 1'b1 || m_en !== 1'b1 || m_addr !== 8'h02) begin
      bad++; $display("FAIL b2b1_gnt got=%b%b/%h want=11/02", d_gnt, m_en, m_addr);
    end
    total++; if (c_rvalid !== 1'b1 || d_rvalid !== 1'b0 || c_rdata !== 32'hA0000001) begin
      bad++; $display("FAIL b2b1_rsp got=c%b d%b %h want=c1 d0 a0000001", c_rvalid, d_rvalid, c_rdata);
    end
    tick();
    idle_inputs();
    c_req = 1'b1; c_addr = 8'h03;
    @(negedge clk);
    total++; if (c_gnt !== 1'b1 || m_addr !== 8'h03) begin
      bad++; $display("FAIL b2b2_gnt got=%b/%h want=1/03", c_gnt, m_addr);
    end
    total++; if (d_rvalid !== 1'b1 || c_rvalid !== 1'b0 || d_rdata !== 32'hB0000002) begin
      bad++; $display("FAIL b2b2_rsp got=c%b d%b %h want=c0 d1 b0000002", c_rvalid, d_rvalid, d_rdata);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    total++; if (c_rvalid !== 1'b1 || d_rvalid !== 1'b0 || c_rdata !== 32'hC0000003) begin
      bad++; $display("FAIL b2b3_rsp got=c%b d%b %h want=c1 d0 c0000003", c_rvalid, d_rvalid, c_rdata);
    end
    total++; if (d_rdata !== 32'hB0000002) begin
      bad++; $display("FAIL b2b3_d_hold got=%h want=b0000002", d_rdata);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[1]  = 32'hA0000001;
    mem[2]  = 32'hB0000002;
    mem[3]  = 32'hC0000003;
    mem[5]  = 32'h1234ABCD;
    m_rdata = '0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_dbg_write_read();
    test_contention();
    test_reset_discard();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm_mem_arbiter.md
SM_MEM_ARBITER -- requirements
Module: sm_mem_arbiter

Interface
REQ-001 Parameter AW, default 8: word-address width of the shared data memory.
REQ-002 Parameter DW, default 32: data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 c_req  input  1  CPU data-port request; held with c_we/c_addr/c_wdata stable until c_gnt.
REQ-006 c_we  input  1  CPU write (1) / read (0).
REQ-007 c_addr  input  AW  CPU word address.
REQ-008 c_wdata  input  DW  CPU write data.
REQ-009 c_gnt  output  1  CPU request accepted this cycle.
REQ-010 c_rvalid  output  1  CPU read data valid.
REQ-011 c_rdata  output  DW  CPU read data.
REQ-012 c_stall  output  1  CPU must hold; equals c_req & ~c_gnt; drives CPU clock-enable gating.
REQ-013 d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: debug/loader port, same directions, widths and rules as the c_* set.
REQ-014 m_en  output  1  memory access strobe.
REQ-015 m_we  output  1  memory write enable.
REQ-016 m_addr  output  AW  memory word address.
REQ-017 m_wdata  output  DW  memory write data.
REQ-018 m_rdata  input  DW  memory read data, valid exactly one cycle after m_en & ~m_we.

Function
REQ-019 At most one gnt per cycle; gnt is combinational from req and arbitration state; m_en = c_gnt | d_gnt; m_we/m_addr/m_wdata are muxed from the granted port in the same cycle.
REQ-020 Sole requester is granted the same cycle it asserts req (zero arbitration latency).
REQ-021 Read response: the granted port's rvalid is asserted exactly one cycle after its read grant, with rdata = m_rdata; the other port's rvalid stays 0.
REQ-022 Writes produce no rvalid; write completes at the grant edge.
REQ-023 rdata of a port not in rvalid holds its last value (registered response tag; no X propagation).
REQ-024 Back-to-back: a new grant is allowed in the cycle a previous read's rvalid is returned (full throughput, one access per cycle).
REQ-025 Arbitration state: 1-bit last_winner register, updated to the granted port on every grant, unchanged when idle.
REQ-026 Simultaneous c_req and d_req: winner per REQ-032; loser gnt=0, loser must hold request.
REQ-027 Request withdrawn before grant: legal only for d_*; CPU never withdraws while c_stall.
REQ-028 Response-tag register (rd_pending, rd_port) records read grant for one cycle; cleared when no read granted.

Reset
REQ-029 While rst=1 at a clock edge: c_gnt=d_gnt=0, m_en=0, c_rvalid=d_rvalid=0, c_rdata=d_rdata=0, last_winner=debug (so CPU wins first contention), rd_pending=0.
REQ-030 Reset asserted in the cycle after a read grant discards that response: no rvalid emitted.
REQ-031 First grant possible in the first cycle with rst=0.

Configuration
REQ-032 Macro SM_MEM_ARB_RR_EN defined: round-robin on contention, winner = port other than last_winner. Undefined: fixed priority, CPU always wins contention; last_winner still maintained but unused for selection.

Structure
REQ-033 Shared package sm_mem_arb_pkg holds port-index constants (PORT_CPU=0, PORT_DBG=1) and the response-tag type.
REQ-034 One sub-module sm_arb_rr2: 2-requester grant logic with last_winner state and enable input; the top handles muxing and response tagging.

Verification
REQ-035 After reset, c_req read addr 0x05, mem[5]=0x1234ABCD -> c_gnt same cycle, c_rvalid next cycle, c_rdata=0x1234ABCD, d_rvalid=0.
REQ-036 d_req write addr 0x10 data 0xDEADBEEF, then c_req read 0x10 next cycle -> c_rdata=0xDEADBEEF one cycle after c_gnt.
REQ-037 Both requesting continuously 6 cycles, RR_EN defined -> grants C,D,C,D,C,D; undefined -> C x6, d_gnt=0, d stalled throughout.
REQ-038 Contention: c_stall=1 exactly in cycles where c_req=1 and d_gnt=1; released cycle after.
REQ-039 Read grant at cycle N, rst=1 at cycle N+1 -> no rvalid on either port, all outputs 0, next contention won by CPU.
REQ-040 Alternating reads C(0x01), D(0x02), C(0x03) back-to-back -> one access per cycle, each rvalid on the correct port with matching data, no cross-delivery.
